// File: rtl/usd_cmd_arbiter_if.sv
// Request/response and FIFO-side signals of the uSD command arbiter.
// The arbiter uses the slave view; requesters and FIFOs sit on the master view.
interface usd_cmd_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    reqValid;
    logic [NUM_REQ*72-1:0] reqCmd;
    logic [NUM_REQ-1:0]    reqReady;
    logic [NUM_REQ-1:0]    rspValid;
    logic [35:0]           rspData;
    logic                  timeoutErr;
    logic                  busy;
    logic [71:0]           cmdFifoData;
    logic                  cmdFifoWrEn;
    logic                  cmdRdyRd;
    logic                  resultFifoRdEn;
    logic [35:0]           resultFifoData;
    logic                  resultPending;

    modport slave (
        input  reqValid, reqCmd, cmdRdyRd, resultFifoData, resultPending,
        output reqReady, rspValid, rspData, timeoutErr, busy,
               cmdFifoData, cmdFifoWrEn, resultFifoRdEn
    );

    modport master (
        output reqValid, reqCmd, cmdRdyRd, resultFifoData, resultPending,
        input  reqReady, rspValid, rspData, timeoutErr, busy,
               cmdFifoData, cmdFifoWrEn, resultFifoRdEn
    );
endinterface

// File: rtl/usd_cmd_arbiter.sv
// Round-robin arbiter sharing one uSD command/result FIFO pair between
// NUM_REQ requesters, one outstanding command at a time, with result timeout.
module usd_cmd_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int REQ_IDX_W   = 2,
    parameter int TIMEOUT_CYC = 1048576
) (
    input  logic               apuClk,
    input  logic               sysRstN,
    usd_cmd_arbiter_if.slave   bus
);
    localparam int TIMER_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TIMER_W-1:0]   TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);
    localparam logic [NUM_REQ-1:0]   ONE_HOT0   = NUM_REQ'(1);
    localparam logic [REQ_IDX_W-1:0] LAST_IDX   = REQ_IDX_W'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        IDLE, DRAIN, DLAT, ISSUE, WAIT, POP, LAT, RETURN
    } state_t;

    state_t                 state;
    logic [REQ_IDX_W-1:0]   lastGrant;
    logic [REQ_IDX_W-1:0]   grant;
    logic [3:0]             staleCnt;
    logic [TIMER_W-1:0]     timer;
    logic [71:0]            cmdLatch;
    logic [NUM_REQ-1:0]     reqReadyQ;
    logic [NUM_REQ-1:0]     rspValidQ;
    logic [35:0]            rspDataQ;
    logic                   timeoutErrQ;
    logic                   busyQ;
    logic                   cmdWrEnQ;
    logic                   rdEnQ;

    logic [71:0]            cmdSlice [NUM_REQ];
    logic [REQ_IDX_W-1:0]   pick;
    logic [REQ_IDX_W-1:0]   candIdx;
    int                     cand;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
        assign cmdSlice[gi] = bus.reqCmd[72*gi +: 72];
    end

    // Walk offsets from farthest to nearest so the nearest valid requester
    // after lastGrant wins; offset NUM_REQ lands back on lastGrant itself.
    always_comb begin
        pick    = '0;
        cand    = 0;
        candIdx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand    = (int'(lastGrant) + k) % NUM_REQ;
            candIdx = REQ_IDX_W'(cand);
            if (bus.reqValid[candIdx]) begin
                pick = candIdx;
            end
        end
    end

    always_ff @(posedge apuClk or negedge sysRstN) begin
        if (!sysRstN) begin
            state       <= IDLE;
            lastGrant   <= LAST_IDX;
            grant       <= '0;
            staleCnt    <= '0;
            timer       <= '0;
            cmdLatch    <= '0;
            reqReadyQ   <= '0;
            rspValidQ   <= '0;
            rspDataQ    <= '0;
            timeoutErrQ <= 1'b0;
            busyQ       <= 1'b0;
            cmdWrEnQ    <= 1'b0;
            rdEnQ       <= 1'b0;
        end else begin
            reqReadyQ   <= '0;
            rspValidQ   <= '0;
            timeoutErrQ <= 1'b0;
            cmdWrEnQ    <= 1'b0;
            rdEnQ       <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.resultPending) begin
                        state <= DRAIN;
                        rdEnQ <= 1'b1;
                        busyQ <= 1'b1;
                    end else if ((|bus.reqValid) && bus.cmdRdyRd) begin
                        grant     <= pick;
                        cmdLatch  <= cmdSlice[pick];
                        cmdWrEnQ  <= 1'b1;
                        reqReadyQ <= ONE_HOT0 << pick;
                        state     <= ISSUE;
                        busyQ     <= 1'b1;
                    end
                end
                DRAIN: state <= DLAT;
                DLAT: begin
                    if (staleCnt != 4'd0) begin
                        staleCnt <= staleCnt - 4'd1;
                    end
                    state <= IDLE;
                    busyQ <= 1'b0;
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    timer <= timer + 1'b1;
                    if (bus.resultPending) begin
                        state <= POP;
                        rdEnQ <= 1'b1;
                    end else if (timer == TIMER_LAST) begin
                        // The stale counter remembers a result still owed by the card.
                        rspDataQ    <= {4'hF, 32'hFFFF_FFFF};
                        rspValidQ   <= ONE_HOT0 << grant;
                        timeoutErrQ <= 1'b1;
                        if (staleCnt != 4'hF) begin
                            staleCnt <= staleCnt + 4'd1;
                        end
                        state <= RETURN;
                    end
                end
                POP: state <= LAT;
                LAT: begin
                    rspDataQ  <= bus.resultFifoData;
                    rspValidQ <= ONE_HOT0 << grant;
                    state     <= RETURN;
                end
                RETURN: begin
                    lastGrant <= grant;
                    state     <= IDLE;
                    busyQ     <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busyQ <= 1'b0;
                end
            endcase
        end
    end

    assign bus.reqReady       = reqReadyQ;
    assign bus.rspValid       = rspValidQ;
    assign bus.rspData        = rspDataQ;
    assign bus.timeoutErr     = timeoutErrQ;
    assign bus.busy           = busyQ;
    assign bus.cmdFifoData    = cmdLatch;
    assign bus.cmdFifoWrEn    = cmdWrEnQ;
    assign bus.resultFifoRdEn = rdEnQ;
endmodule

// File: tb/tb_usd_cmd_arbiter.sv
// Directed bench for usd_cmd_arbiter with a behavioural result FIFO and a
// command-write monitor; expected values are hand-derived per scenario.
module tb_usd_cmd_arbiter;
    localparam int NREQ = 4;
    localparam int TO   = 64;

    logic apuClk  = 1'b0;
    logic sysRstN = 1'b0;

    usd_cmd_arbiter_if #(.NUM_REQ(NREQ)) bus ();

    usd_cmd_arbiter #(
        .NUM_REQ(NREQ), .REQ_IDX_W(2), .TIMEOUT_CYC(TO)
    ) dut (
        .apuClk  (apuClk),
        .sysRstN (sysRstN),
        .bus     (bus.slave)
    );

    always #5 apuClk = ~apuClk;

    int errors = 0;
    int checks = 0;

    // Result FIFO model: push on injValid, pop on rd_en, dout valid next cycle.
    logic [35:0] resMem [8];
    int          resWr   = 0;
    int          resRd   = 0;
    int          resCnt  = 0;
    logic        injValid = 1'b0;
    logic [35:0] injWord  = '0;
    int          wrCount = 0;
    int          rdCount = 0;

    always @(posedge apuClk) begin
        if (injValid) begin
            resMem[resWr % 8] <= injWord;
            resWr <= resWr + 1;
        end
        if (bus.resultFifoRdEn && resCnt != 0) begin
            bus.resultFifoData <= resMem[resRd % 8];
            resRd <= resRd + 1;
        end
        resCnt <= resCnt + (injValid ? 1 : 0) - ((bus.resultFifoRdEn && resCnt != 0) ? 1 : 0);
        if (bus.cmdFifoWrEn) wrCount <= wrCount + 1;
        if (bus.resultFifoRdEn) rdCount <= rdCount + 1;
    end

    assign bus.resultPending = (resCnt != 0);

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] cmdFor(input int i);
        return {8'h10 + 8'(i), 64'hC0DE_0000_0000_0000 | 64'(i)};
    endfunction

    task automatic waitReady(output int cyc);
        cyc = 0;
        do begin
            @(negedge apuClk);
            cyc++;
        end while (bus.reqReady == '0 && cyc < 200);
        if (bus.reqReady == '0) chk("ready_timeout", 72'(cyc), 72'(0));
    endtask

    task automatic waitRsp(output int cyc, output logic [3:0] rv,
                           output logic [35:0] rd, output logic te);
        cyc = 0;
        do begin
            @(negedge apuClk);
            cyc++;
        end while (bus.rspValid == '0 && cyc < 300);
        if (bus.rspValid == '0) chk("rsp_timeout", 72'(cyc), 72'(0));
        rv = bus.rspValid;
        rd = bus.rspData;
        te = bus.timeoutErr;
    endtask

    task automatic inject(input logic [35:0] w);
        injWord  = w;
        injValid = 1'b1;
        @(negedge apuClk);
        injValid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int base;
        int bad;
        int rspSeen;
        int rd0;
        logic [3:0]  rv;
        logic [35:0] rd;
        logic        te;
        int expG [5] = '{0, 1, 2, 3, 0};

        bus.reqValid = '0;
        bus.reqCmd   = '0;
        bus.cmdRdyRd = 1'b1;
        for (int i = 0; i < NREQ; i++) bus.reqCmd[72*i +: 72] = cmdFor(i);
        repeat (3) @(negedge apuClk);

        chk("rst_busy",   72'(bus.busy), 72'(0));
        chk("rst_ready",  72'(bus.reqReady), 72'(0));
        chk("rst_rspv",   72'(bus.rspValid), 72'(0));
        chk("rst_rspd",   72'(bus.rspData), 72'(0));
        chk("rst_wren",   72'(bus.cmdFifoWrEn), 72'(0));
        chk("rst_rden",   72'(bus.resultFifoRdEn), 72'(0));
        chk("rst_toerr",  72'(bus.timeoutErr), 72'(0));
        sysRstN = 1'b1;
        @(negedge apuClk);

        // Round-robin with every requester held valid.
        bus.reqValid = 4'b1111;
        base = wrCount;
        for (int t = 0; t < 5; t++) begin
            waitReady(c);
            chk("rr_grant", 72'(bus.reqReady), 72'(4'b0001 << expG[t]));
            chk("rr_cmd", bus.cmdFifoData, cmdFor(expG[t]));
            repeat (4) @(negedge apuClk);
            inject(36'h0_0000_0A00 + 36'(t));
            waitRsp(c, rv, rd, te);
            if (t == 4) bus.reqValid = '0;
            chk("rr_rspv", 72'(rv), 72'(4'b0001 << expG[t]));
            chk("rr_rspd", 72'(rd), 72'(36'h0_0000_0A00 + 36'(t)));
            chk("rr_wrcnt", 72'(wrCount - base), 72'(t + 1));
            $display("txn rr t=%0d grant=%b rsp=%h", t, rv, rd);
        end
        repeat (2) @(negedge apuClk);

        // Single request: last grant was 0, requester 0 wraps back to itself.
        bus.reqCmd[71:0] = 72'h40_0000_0000_0000_0000;
        bus.reqValid = 4'b0001;
        base = wrCount;
        waitReady(c);
        bus.reqValid = '0;
        chk("single_lat", 72'(c), 72'(1));
        chk("single_grant", 72'(bus.reqReady), 72'(4'b0001));
        chk("single_wren", 72'(bus.cmdFifoWrEn), 72'(1));
        chk("single_cmd", bus.cmdFifoData, 72'h40_0000_0000_0000_0000);
        repeat (9) @(negedge apuClk);
        inject(36'h0_0000_0900);
        waitRsp(c, rv, rd, te);
        chk("single_rsplat", 72'(c), 72'(3));
        chk("single_rspv", 72'(rv), 72'(4'b0001));
        chk("single_rspd", 72'(rd), 72'(36'h0_0000_0900));
        chk("single_toerr", 72'(te), 72'(0));
        chk("single_wrcnt", 72'(wrCount - base), 72'(1));
        $display("txn single grant=%b rsp=%h lat=%0d", rv, rd, c);
        @(negedge apuClk);

        // Backpressure: command FIFO full keeps the arbiter idle.
        bus.cmdRdyRd = 1'b0;
        bus.reqValid = 4'b0100;
        base = wrCount;
        bad  = 0;
        repeat (50) begin
            @(negedge apuClk);
            if (bus.busy || bus.cmdFifoWrEn || bus.reqReady != '0) bad++;
        end
        chk("bp_idle", 72'(bad), 72'(0));
        chk("bp_nowrite", 72'(wrCount - base), 72'(0));
        bus.cmdRdyRd = 1'b1;
        waitReady(c);
        bus.reqValid = '0;
        chk("bp_lat", 72'(c), 72'(1));
        chk("bp_grant", 72'(bus.reqReady), 72'(4'b0100));
        inject(36'h0_1234_5678);
        waitRsp(c, rv, rd, te);
        chk("bp_rspv", 72'(rv), 72'(4'b0100));
        chk("bp_rspd", 72'(rd), 72'(36'h0_1234_5678));
        $display("txn backpressure grant=%b rsp=%h", rv, rd);
        @(negedge apuClk);

        // Timeout: ISSUE, then TO cycles in WAIT, then RETURN.
        bus.reqValid = 4'b0010;
        waitReady(c);
        bus.reqValid = '0;
        chk("to_grant", 72'(bus.reqReady), 72'(4'b0010));
        waitRsp(c, rv, rd, te);
        chk("to_lat", 72'(c), 72'(TO + 1));
        chk("to_rspv", 72'(rv), 72'(4'b0010));
        chk("to_rspd", 72'(rd), 72'(36'hF_FFFF_FFFF));
        chk("to_err", 72'(te), 72'(1));
        chk("to_stale", 72'(dut.staleCnt), 72'(1));
        $display("txn timeout grant=%b rsp=%h err=%0d lat=%0d", rv, rd, te, c);
        @(negedge apuClk);
        rd0 = rdCount;
        inject(36'h0_DEAD_0001);
        rspSeen = 0;
        repeat (8) begin
            @(negedge apuClk);
            if (bus.rspValid != '0) rspSeen++;
        end
        chk("late_drain", 72'(rdCount - rd0), 72'(1));
        chk("late_norsp", 72'(rspSeen), 72'(0));
        chk("late_stale", 72'(dut.staleCnt), 72'(0));
        chk("late_busy", 72'(bus.busy), 72'(0));
        $display("txn late-drain pops=%0d rsp=%0d", rdCount - rd0, rspSeen);

        // Result becomes visible in the same WAIT cycle the timer expires.
        bus.reqValid = 4'b1000;
        waitReady(c);
        bus.reqValid = '0;
        chk("sim_grant", 72'(bus.reqReady), 72'(4'b1000));
        repeat (TO - 1) @(negedge apuClk);
        inject(36'h0_5555_AAAA);
        waitRsp(c, rv, rd, te);
        chk("sim_rsplat", 72'(c), 72'(3));
        chk("sim_rspv", 72'(rv), 72'(4'b1000));
        chk("sim_rspd", 72'(rd), 72'(36'h0_5555_AAAA));
        chk("sim_toerr", 72'(te), 72'(0));
        chk("sim_stale", 72'(dut.staleCnt), 72'(0));
        $display("txn simultaneous grant=%b rsp=%h err=%0d", rv, rd, te);
        @(negedge apuClk);

        // Make requester 0 the last grant, then reset while 1 is waiting.
        bus.reqValid = 4'b0001;
        waitReady(c);
        bus.reqValid = '0;
        inject(36'h0_0000_0111);
        waitRsp(c, rv, rd, te);
        chk("pre_rspv", 72'(rv), 72'(4'b0001));
        @(negedge apuClk);
        bus.reqValid = 4'b0011;
        waitReady(c);
        bus.reqValid = '0;
        chk("pre_grant", 72'(bus.reqReady), 72'(4'b0010));
        repeat (5) @(negedge apuClk);
        #2 sysRstN = 1'b0;
        #1;
        chk("mid_busy", 72'(bus.busy), 72'(0));
        chk("mid_outs", 72'({bus.reqReady, bus.rspValid, bus.cmdFifoWrEn,
                             bus.resultFifoRdEn, bus.timeoutErr}), 72'(0));
        chk("mid_rspd", 72'(bus.rspData), 72'(0));
        chk("mid_last", 72'(dut.lastGrant), 72'(NREQ - 1));
        @(negedge apuClk);
        sysRstN = 1'b1;
        @(negedge apuClk);
        rd0 = rdCount;
        inject(36'h0_0000_0222);
        rspSeen = 0;
        repeat (6) begin
            @(negedge apuClk);
            if (bus.rspValid != '0) rspSeen++;
        end
        chk("rst_drain", 72'(rdCount - rd0), 72'(1));
        chk("rst_norsp", 72'(rspSeen), 72'(0));
        bus.reqValid = 4'b0011;
        waitReady(c);
        bus.reqValid = '0;
        chk("post_grant", 72'(bus.reqReady), 72'(4'b0001));
        inject(36'h0_0000_0333);
        waitRsp(c, rv, rd, te);
        chk("post_rspv", 72'(rv), 72'(4'b0001));
        chk("post_rspd", 72'(rd), 72'(36'h0_0000_0333));
        $display("txn post-reset grant=%b rsp=%h", rv, rd);
        repeat (2) @(negedge apuClk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
